// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin arbiter granting two requesters access to one SPI register controller.
// Ports:
//   i_clk_sys, i_rst_n           system clock (rising edge), asynchronous active-low reset
//   i_reqN/i_rwN/i_addrN/i_wdataN requester N command (level request, 1 = read)
//   o_doneN/o_errN/o_rdataN      requester N completion pulse, timeout flag, held read data
//   o_spi_start/rw/addr/data     one-cycle start pulse and latched command to the SPI controller
//   i_spi_data_valid/i_spi_data  controller end-of-transaction pulse and read data
//   o_busy, o_grant              non-IDLE indicator, owner of current/last transaction
module spi_arbiter #(
    parameter int SPI_ADDR_WIDTH = 6,
    parameter int SPI_DATA_WIDTH = 20,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                      i_clk_sys,
    input  logic                      i_rst_n,
    input  logic                      i_req0,
    input  logic                      i_req1,
    input  logic                      i_rw0,
    input  logic                      i_rw1,
    input  logic [SPI_ADDR_WIDTH-1:0] i_addr0,
    input  logic [SPI_ADDR_WIDTH-1:0] i_addr1,
    input  logic [SPI_DATA_WIDTH-1:0] i_wdata0,
    input  logic [SPI_DATA_WIDTH-1:0] i_wdata1,
    output logic                      o_done0,
    output logic                      o_done1,
    output logic                      o_err0,
    output logic                      o_err1,
    output logic [SPI_DATA_WIDTH-1:0] o_rdata0,
    output logic [SPI_DATA_WIDTH-1:0] o_rdata1,
    output logic                      o_spi_start,
    output logic                      o_spi_rw,
    output logic [SPI_ADDR_WIDTH-1:0] o_spi_addr,
    output logic [SPI_DATA_WIDTH-1:0] o_spi_data,
    input  logic                      i_spi_data_valid,
    input  logic [SPI_DATA_WIDTH-1:0] i_spi_data,
    output logic                      o_busy,
    output logic                      o_grant
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt;
    logic            last;
    logic            err;
    logic            timeout;
    logic            win;

    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    // On a tie the requester that did not win last time goes next.
    assign win = (i_req0 && i_req1) ? ~last : i_req1;

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = (i_req0 || i_req1) ? START : IDLE;
            START:   state_nxt = WAIT;
            WAIT:    state_nxt = (i_spi_data_valid || timeout) ? DONE : WAIT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_spi_start = state == START;
        o_busy      = state != IDLE;
        o_done0     = state == DONE && !o_grant;
        o_done1     = state == DONE && o_grant;
        o_err0      = o_done0 && err;
        o_err1      = o_done1 && err;
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_grant    <= 1'b0;
            last       <= 1'b1;
            o_spi_rw   <= 1'b0;
            o_spi_addr <= '0;
            o_spi_data <= '0;
            o_rdata0   <= '0;
            o_rdata1   <= '0;
            cnt        <= '0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_req0 || i_req1) begin
                    o_grant    <= win;
                    o_spi_rw   <= win ? i_rw1 : i_rw0;
                    o_spi_addr <= win ? i_addr1 : i_addr0;
                    o_spi_data <= win ? i_wdata1 : i_wdata0;
                end
                START: cnt <= '0;
                WAIT: begin
                    // Valid beats a coincident timeout.
                    if (i_spi_data_valid) begin
                        err <= 1'b0;
                        if (o_spi_rw && o_grant)  o_rdata1 <= i_spi_data;
                        if (o_spi_rw && !o_grant) o_rdata0 <= i_spi_data;
                    end else if (timeout) begin
                        err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    last <= o_grant;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: scoreboard bench for spi_arbiter with a behavioural SPI controller.
module tb_spi_arbiter;
    localparam int AW = 6;
    localparam int DW = 20;
    localparam int TO = 16;

    typedef struct {
        bit            p;
        bit            err;
        logic [DW-1:0] rd;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0, req1, rw0, rw1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          o_done0, o_done1, o_err0, o_err1;
    logic [DW-1:0] o_rdata0, o_rdata1;
    logic          o_spi_start, o_spi_rw;
    logic [AW-1:0] o_spi_addr;
    logic [DW-1:0] o_spi_data;
    logic          spi_valid;
    logic [DW-1:0] spi_data;
    logic          o_busy, o_grant;

    int            n_chk = 0;
    int            n_fail = 0;
    int            starts = 0;
    int            ctl_k = 0;
    logic [DW-1:0] ctl_data = '0;
    logic [DW-1:0] m_rd [2];
    exp_t          q [$];
    exp_t          mx;

    spi_arbiter #(.SPI_ADDR_WIDTH(AW), .SPI_DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .i_clk_sys(clk), .i_rst_n(rst_n),
        .i_req0(req0), .i_req1(req1), .i_rw0(rw0), .i_rw1(rw1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_done0(o_done0), .o_done1(o_done1), .o_err0(o_err0), .o_err1(o_err1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .o_spi_start(o_spi_start), .o_spi_rw(o_spi_rw), .o_spi_addr(o_spi_addr), .o_spi_data(o_spi_data),
        .i_spi_data_valid(spi_valid), .i_spi_data(spi_data),
        .o_busy(o_busy), .o_grant(o_grant)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // SPI controller: answers each start ctl_k cycles later (ctl_k = 0 never answers).
    initial begin
        int            kk;
        logic [DW-1:0] dd;
        spi_valid = 1'b0;
        spi_data  = '0;
        forever begin
            @(negedge clk);
            if (o_spi_start && ctl_k > 0) begin
                kk = ctl_k;
                dd = ctl_data;
                repeat (kk) @(negedge clk);
                spi_valid = 1'b1;
                spi_data  = dd;
                @(negedge clk);
                spi_valid = 1'b0;
            end
        end
    end

    // Monitor: every completion pulse is matched against the next expected entry.
    always @(negedge clk) begin
        if (o_spi_start) starts++;
        if (o_done0 || o_done1) begin
            chk("done_exclusive", 32'(o_done0 & o_done1), 0);
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_done: done0=%0b done1=%0b required none at %0t", o_done0, o_done1, $time);
            end else begin
                mx = q.pop_front();
                chk("done_port", 32'(o_done1), 32'(mx.p));
                chk("grant", 32'(o_grant), 32'(mx.p));
                chk("err", 32'(mx.p ? o_err1 : o_err0), 32'(mx.err));
                chk("other_err", 32'(mx.p ? o_err0 : o_err1), 0);
                chk("rdata", 32'(mx.p ? o_rdata1 : o_rdata0), 32'(mx.rd));
            end
        end
    end

    task automatic push(input bit p, input bit e);
        exp_t x;
        x.p   = p;
        x.err = e;
        x.rd  = m_rd[p];
        q.push_back(x);
    endtask

    task automatic run_txn(input bit p, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int k, input logic [DW-1:0] rd, input bit e);
        int lat;
        ctl_k    = k;
        ctl_data = rd;
        if (p) begin rw1 = rw; addr1 = a; wdata1 = wd; req1 = 1'b1; end
        else   begin rw0 = rw; addr0 = a; wdata0 = wd; req0 = 1'b1; end
        for (int i = 0; i < 10 && !o_spi_start; i++) @(negedge clk);
        chk("start_seen", 32'(o_spi_start), 1);
        // Requester inputs change after sampling; the latched command must not.
        if (p) begin rw1 = ~rw; addr1 = ~a; wdata1 = ~wd; end
        else   begin rw0 = ~rw; addr0 = ~a; wdata0 = ~wd; end
        if (!e && rw) m_rd[p] = rd;
        push(p, e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                chk("spi_rw", 32'(o_spi_rw), 32'(rw));
                chk("spi_addr", 32'(o_spi_addr), 32'(a));
                chk("spi_data", 32'(o_spi_data), 32'(wd));
                chk("busy_wait", 32'(o_busy), 1);
            end
        end while (!(o_done0 || o_done1) && lat < 60);
        chk("latency", 32'(lat), 32'((k > 0 && k <= TO) ? k + 1 : TO + 1));
        chk("spi_addr_hold", 32'(o_spi_addr), 32'(a));
        if (p) req1 = 1'b0;
        else   req0 = 1'b0;
    endtask

    initial begin
        int nd;
        int st0;
        rst_n = 1'b1;
        {req0, req1, rw0, rw1} = '0;
        {addr0, addr1, wdata0, wdata1} = '0;
        m_rd[0] = '0;
        m_rd[1] = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_start", 32'(o_spi_start), 0);
        chk("rst_done", 32'(o_done0 | o_done1), 0);
        chk("rst_err", 32'(o_err0 | o_err1), 0);
        chk("rst_grant", 32'(o_grant), 0);
        chk("rst_spi_addr", 32'(o_spi_addr), 0);
        chk("rst_rdata0", 32'(o_rdata0), 0);
        chk("rst_rdata1", 32'(o_rdata1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Both requesters held: grants alternate starting with requester 0.
        ctl_k = 2; ctl_data = 20'h55555;
        rw0 = 1'b1; addr0 = 6'h01; rw1 = 1'b0; addr1 = 6'h02; wdata1 = 20'h00777;
        m_rd[0] = 20'h55555;
        for (int i = 0; i < 6; i++) push(i[0], 1'b0);
        st0 = starts; nd = 0;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 200 && nd < 6; i++) begin
            @(negedge clk);
            if (o_done0 || o_done1) nd++;
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("contention_dones", 32'(nd), 6);
        @(negedge clk); #1;
        chk("contention_starts", 32'(starts - st0), 6);

        st0 = starts;
        run_txn(1'b0, 1'b1, 6'h05, 20'h00000, 10, 20'hABCDE, 1'b0);
        @(negedge clk); #1;
        chk("single_read_starts", 32'(starts - st0), 1);

        run_txn(1'b1, 1'b0, 6'h3F, 20'h12345, 5, 20'hBADBA, 1'b0);

        run_txn(1'b1, 1'b1, 6'h10, 20'h00000, 0, 20'h00000, 1'b1);
        run_txn(1'b1, 1'b1, 6'h11, 20'h00000, TO, 20'h0F0F0, 1'b0);
        // Late answer lands in IDLE after the timeout and must be ignored.
        run_txn(1'b1, 1'b1, 6'h12, 20'h00000, TO + 4, 20'hFFFFF, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("idle_busy", 32'(o_busy), 0);
        end
        chk("spurious_rdata1", 32'(o_rdata1), 32'(20'h0F0F0));
        chk("spurious_rdata0", 32'(o_rdata0), 32'(20'hABCDE));

        // Reset in the middle of WAIT aborts without a completion.
        ctl_k = 0;
        rw1 = 1'b1; addr1 = 6'h07; req1 = 1'b1;
        for (int i = 0; i < 10 && !o_spi_start; i++) @(negedge clk);
        chk("abort_start_seen", 32'(o_spi_start), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        chk("abort_busy", 32'(o_busy), 0);
        chk("abort_grant", 32'(o_grant), 0);
        chk("abort_spi_addr", 32'(o_spi_addr), 0);
        chk("abort_rdata0", 32'(o_rdata0), 0);
        chk("abort_rdata1", 32'(o_rdata1), 0);
        m_rd[0] = '0;
        m_rd[1] = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // First tie after reset goes to requester 0.
        rw1 = 1'b0; addr1 = 6'h22; req1 = 1'b1;
        run_txn(1'b0, 1'b1, 6'h21, 20'h00000, 3, 20'h13579, 1'b0);
        req1 = 1'b0;

        repeat (6) @(negedge clk);
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter SPI_ADDR_WIDTH, default 6, SPI register address width.
REQ-002 The block SHALL have parameter SPI_DATA_WIDTH, default 20, SPI register data width.
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, maximum WAIT-state cycles before abort (minimum 2).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: i_clk_sys  input  1  system clock, all logic on rising edge.
REQ-005 i_rst_n  input  1  asynchronous active-low reset.
REQ-006 i_req0 / i_req1  input  1  requester 0/1 transaction request, level.
REQ-007 i_rw0 / i_rw1  input  1  requester 0/1 direction, 1 = read, 0 = write.
REQ-008 i_addr0 / i_addr1  input  SPI_ADDR_WIDTH  requester 0/1 register address.
REQ-009 i_wdata0 / i_wdata1  input  SPI_DATA_WIDTH  requester 0/1 write data.
REQ-010 o_done0 / o_done1  output  1  one-cycle completion pulse to requester 0/1.
REQ-011 o_err0 / o_err1  output  1  timeout flag, valid with o_doneN.
REQ-012 o_rdata0 / o_rdata1  output  SPI_DATA_WIDTH  read data, valid from o_doneN, held until that port's next o_doneN.
REQ-013 o_spi_start  output  1  one-cycle start pulse to the SPI controller.
REQ-014 o_spi_rw, o_spi_addr, o_spi_data  output  1 / SPI_ADDR_WIDTH / SPI_DATA_WIDTH  latched command to the SPI controller.
REQ-015 i_spi_data_valid  input  1  SPI controller end-of-transaction pulse (read and write).
REQ-016 i_spi_data  input  SPI_DATA_WIDTH  SPI controller read data, valid with i_spi_data_valid.
REQ-017 o_busy  output  1  high in every state except IDLE.
REQ-018 o_grant  output  1  index of requester owning the current/last transaction.

Function
REQ-019 State machine SHALL have states IDLE, START, WAIT, DONE.
REQ-020 IDLE: no request -> stay; request(s) present -> select winner, latch its rw/addr/wdata into o_spi_* and o_grant, go START.
REQ-021 Arbitration: single requester wins; both requesting -> the requester not equal to last-granted wins (round-robin).
REQ-022 START: o_spi_start = 1 for exactly this one cycle; clear timeout counter; go WAIT.
REQ-023 WAIT: i_spi_data_valid = 1 -> capture i_spi_data into o_rdataN of granted port if rw = 1 (writes leave o_rdataN unchanged), errN = 0, go DONE.
REQ-024 WAIT: counter increments each cycle; counter = TIMEOUT_CYCLES-1 without valid -> errN = 1, o_rdataN unchanged, go DONE.
REQ-025 Valid and timeout in the same cycle: valid wins, errN = 0.
REQ-026 DONE: o_doneN = 1 for granted port only, one cycle; update last-granted; go IDLE.
REQ-027 i_spi_data_valid outside WAIT SHALL be ignored.
REQ-028 o_spi_rw/addr/data SHALL stay stable from START through DONE; requester inputs may change after IDLE sampling without effect.
REQ-029 Requesters deassert i_reqN on the edge o_doneN is seen; a request still high in the following IDLE cycle is a new transaction.
REQ-030 Latency: request sampled in IDLE cycle t -> o_spi_start at t+1 -> valid at t+1+k (k>=1) -> o_doneN at t+2+k; back-to-back idle gap exactly one cycle.

Reset
REQ-031 Reset asserted (any state, including mid-transaction) SHALL immediately force IDLE, all outputs 0, counter 0, last-granted = 1 (requester 0 wins first tie); aborted transaction produces no o_doneN.

Verification
REQ-032 Single read: req0, rw0=1, addr0=6'h05; controller returns valid 10 cycles after start with 20'hABCDE -> one o_spi_start, o_done0 pulse, o_err0=0, o_rdata0=20'hABCDE, o_grant=0.
REQ-033 Contention: req0 and req1 asserted together and held, 3 transactions each -> grants 0,1,0,1,0,1; no o_done on non-granted port.
REQ-034 Write: req1, rw1=0, addr1=6'h3F, wdata1=20'h12345 -> o_spi_addr=6'h3F, o_spi_data=20'h12345 during WAIT; o_done1 pulse; o_rdata1 unchanged.
REQ-035 Timeout: TIMEOUT_CYCLES=16, no valid -> o_done1 with o_err1=1 at 16 WAIT cycles; valid on cycle 16 instead -> o_err1=0.
REQ-036 Reset mid-WAIT: i_rst_n low for 1 cycle -> outputs 0 next sample, no o_done; later tie -> requester 0 granted first.
REQ-037 Spurious i_spi_data_valid in IDLE -> no state change, no o_done, o_rdata unchanged.
